// File: rtl/instruction_store.sv
// instruction_store: byte-stream program loader in front of a 256 x 32 instruction memory.
// Optional trailing XOR checksum stage is compiled in by defining INSTR_STORE_CHECKSUM_EN.
module instruction_store #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        load_start,
    input  logic [7:0]  load_byte,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [7:0]  instruction_pointer,
    output logic [31:0] instruction,
    output logic        cpu_enable,
    output logic        cpu_resetn,
    output logic        load_busy,
    output logic        load_error
);

`ifdef INSTR_STORE_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CHK, S_RUN
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_RUN
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [8:0]  count_q, count_d;
    logic [7:0]  addr_q, addr_d;
    logic [8:0]  words_q, words_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [23:0] buf_q, buf_d;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        accept;
    logic        running;

    // Memory has no reset so a loaded program survives a CPU/system reset.
    logic [31:0] mem_q [DEPTH];

`ifdef INSTR_STORE_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;
    logic       err_q, err_d;
    assign load_error = err_q;
    assign load_ready = (state_q == S_LEN) || (state_q == S_DATA)
                     || (state_q == S_CHK);
`else
    assign load_error = 1'b0;
    assign load_ready = (state_q == S_LEN) || (state_q == S_DATA);
`endif

    assign load_busy   = load_ready;
    assign accept      = load_valid && load_ready;
    assign running     = (state_q == S_RUN);
    assign cpu_enable  = enable && running;
    assign cpu_resetn  = resetn && running;
    assign instruction = mem_q[instruction_pointer];
    assign wr_data     = {buf_q, load_byte};

    // Loader sequencing: load_start always wins over a byte on the same edge.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        words_d = words_q;
        bidx_d  = bidx_q;
        buf_d   = buf_q;
        wr_en   = 1'b0;
`ifdef INSTR_STORE_CHECKSUM_EN
        chk_d   = chk_q;
        err_d   = err_q;
`endif
        if (load_start) begin
            state_d = S_LEN;
            addr_d  = '0;
            words_d = '0;
            bidx_d  = '0;
`ifdef INSTR_STORE_CHECKSUM_EN
            chk_d   = '0;
            err_d   = 1'b0;
`endif
        end else if (accept) begin
            unique case (state_q)
                S_LEN: begin
                    count_d = (load_byte == 8'd0) ? 9'(DEPTH)
                                                  : {1'b0, load_byte};
                    addr_d  = '0;
                    words_d = '0;
                    bidx_d  = '0;
                    state_d = S_DATA;
                end
                S_DATA: begin
`ifdef INSTR_STORE_CHECKSUM_EN
                    chk_d  = chk_q ^ load_byte;
`endif
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        wr_en   = 1'b1;
                        addr_d  = addr_q + 8'd1;
                        words_d = words_q + 9'd1;
                        if (words_q + 9'd1 == count_q) begin
`ifdef INSTR_STORE_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_RUN;
`endif
                        end
                    end else begin
                        buf_d = {buf_q[15:0], load_byte};
                    end
                end
`ifdef INSTR_STORE_CHECKSUM_EN
                S_CHK: begin
                    if (load_byte == chk_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Loader state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            words_q <= '0;
            bidx_q  <= '0;
            buf_q   <= '0;
`ifdef INSTR_STORE_CHECKSUM_EN
            chk_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            bidx_q  <= bidx_d;
            buf_q   <= buf_d;
`ifdef INSTR_STORE_CHECKSUM_EN
            chk_q   <= chk_d;
            err_q   <= err_d;
`endif
        end
    end

    // Word write on acceptance of the fourth byte; read port sees it at once.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_instruction_store.sv
// tb_instruction_store: table vectors, corner sequences and random loads
// checked against a word-array model of the loaded program.
module tb_instruction_store;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        load_start;
    logic [7:0]  load_byte;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  instruction_pointer;
    logic [31:0] instruction;
    logic        cpu_enable;
    logic        cpu_resetn;
    logic        load_busy;
    logic        load_error;

    instruction_store dut (
        .clk                 (clk),
        .resetn              (resetn),
        .enable              (enable),
        .load_start          (load_start),
        .load_byte           (load_byte),
        .load_valid          (load_valid),
        .load_ready          (load_ready),
        .instruction_pointer (instruction_pointer),
        .instruction         (instruction),
        .cpu_enable          (cpu_enable),
        .cpu_resetn          (cpu_resetn),
        .load_busy           (load_busy),
        .load_error          (load_error)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] mdl [256];
    bit          known [256];
    logic [31:0] prog [256];
    bit          running = 1'b0;

    typedef struct {
        logic [31:0] word;
        logic        en;
        logic        exp_ce;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        if ($urandom_range(0, 3) == 0) begin
            load_valid = 1'b0;
            load_byte  = 8'($urandom);
            tick();
        end
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        running = 1'b0;
    endtask

    // Sends count n and the first ndata data bytes of prog[]; model words
    // become valid as each fourth byte is sent.
    task automatic load(input int n, input int ndata, input bit do_start);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'd0;
        if (do_start) start();
        send(8'(n));
        for (int k = 0; k < ndata; k++) begin
            b = 8'(prog[k / 4] >> (8 * (3 - (k % 4))));
            x = x ^ b;
            send(b);
            if (k % 4 == 3) begin
                mdl[k / 4]   = prog[k / 4];
                known[k / 4] = 1'b1;
            end
        end
        if (ndata == 4 * n) begin
`ifdef INSTR_STORE_CHECKSUM_EN
            send(x);
`endif
            running = 1'b1;
        end
    endtask

    task automatic check_mem(input string name);
        logic [7:0] keep;
        keep = instruction_pointer;
        for (int a = 0; a < 256; a++) begin
            if (known[a]) begin
                instruction_pointer = 8'(a);
                #1;
                check(name, instruction, mdl[a]);
            end
        end
        instruction_pointer = keep;
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        enable = 1'b1;
        load_start = 1'b0;
        load_byte = 8'd0;
        load_valid = 1'b0;
        instruction_pointer = 8'd0;

        tbl[0] = '{32'h12345678, 1'b1, 1'b1};
        tbl[1] = '{32'h00000000, 1'b1, 1'b1};
        tbl[2] = '{32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[3] = '{32'hDEADBEEF, 1'b1, 1'b1};
        tbl[4] = '{32'h80000001, 1'b0, 1'b0};
        tbl[5] = '{32'h0F0F0F0F, 1'b1, 1'b1};

        tick();
        tick();
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_busy", 32'(load_busy), 32'd0);
        check("rst_err", 32'(load_error), 32'd0);
        check("rst_cpu_en", 32'(cpu_enable), 32'd0);
        check("rst_cpu_rstn", 32'(cpu_resetn), 32'd0);
        resetn = 1'b1;
        load_valid = 1'b1;
        load_byte = 8'h5A;
        tick();
        tick();
        load_valid = 1'b0;
        check("idle_ready", 32'(load_ready), 32'd0);
        check("idle_cpu_rstn", 32'(cpu_resetn), 32'd0);

        start();
        check("start_busy", 32'(load_busy), 32'd1);
        check("start_ready", 32'(load_ready), 32'd1);
        check("start_cpu_rstn", 32'(cpu_resetn), 32'd0);

        for (int i = 0; i < 6; i++) begin
            enable = tbl[i].en;
            prog[0] = tbl[i].word;
            load(1, 4, 1'b1);
            check("tbl_instr", instruction, tbl[i].word);
            check("tbl_cpu_rstn", 32'(cpu_resetn), 32'd1);
            check("tbl_cpu_en", 32'(cpu_enable), 32'(tbl[i].exp_ce));
            check("tbl_ready", 32'(load_ready), 32'd0);
            check("tbl_busy", 32'(load_busy), 32'd0);
        end
        enable = 1'b1;

        for (int a = 0; a < 256; a++) prog[a] = {4{8'(a)}};
        load(256, 1024, 1'b1);
        check("full_cpu_rstn", 32'(cpu_resetn), 32'd1);
        check("full_ready", 32'(load_ready), 32'd0);
        check_mem("full_mem");

        prog[0] = 32'hAAAA5555;
        prog[1] = 32'h33CC33CC;
        load(2, 6, 1'b1);
        check("abort_mid_rstn", 32'(cpu_resetn), 32'd0);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_byte = 8'h07;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        running = 1'b0;
        check("abort_busy", 32'(load_busy), 32'd1);
        check("abort_cpu_rstn", 32'(cpu_resetn), 32'd0);
        check("abort_cpu_en", 32'(cpu_enable), 32'd0);
        prog[0] = 32'hCAFEF00D;
        load(1, 4, 1'b0);
        check("abort_done_rstn", 32'(cpu_resetn), 32'd1);
        check_mem("abort_mem");

        for (int a = 0; a < 3; a++) prog[a] = $urandom;
        load(3, 6, 1'b1);
        resetn = 1'b0;
        #1;
        check("arst_ready", 32'(load_ready), 32'd0);
        check("arst_busy", 32'(load_busy), 32'd0);
        check("arst_err", 32'(load_error), 32'd0);
        check("arst_cpu_en", 32'(cpu_enable), 32'd0);
        check("arst_cpu_rstn", 32'(cpu_resetn), 32'd0);
        tick();
        resetn = 1'b1;
        running = 1'b0;
        for (int c = 0; c < 8; c++) begin
            load_valid = 1'($urandom);
            load_byte = 8'($urandom);
            tick();
            check("arst_idle_ready", 32'(load_ready), 32'd0);
            check("arst_idle_rstn", 32'(cpu_resetn), 32'd0);
        end
        load_valid = 1'b0;
        check_mem("arst_mem");

        prog[0] = $urandom;
        prog[1] = $urandom;
        load(2, 8, 1'b1);
        for (int c = 0; c < 40; c++) begin
            load_valid = 1'($urandom);
            load_byte = 8'($urandom);
            tick();
            check("run_ready", 32'(load_ready), 32'd0);
            check("run_rstn", 32'(cpu_resetn), 32'd1);
        end
        load_valid = 1'b0;
        check_mem("run_mem");

        for (int it = 0; it < 15; it++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int a = 0; a < n; a++) prog[a] = $urandom;
            load(n, 4 * n, 1'b1);
            check("rnd_rstn", 32'(cpu_resetn), 32'(running));
            check("rnd_busy", 32'(load_busy), 32'd0);
            check_mem("rnd_mem");
        end

`ifdef INSTR_STORE_CHECKSUM_EN
        start();
        send(8'd1);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        mdl[0] = 32'h01020304;
        send(8'h05);
        check("chk_bad_err", 32'(load_error), 32'd1);
        check("chk_bad_rstn", 32'(cpu_resetn), 32'd0);
        check("chk_bad_busy", 32'(load_busy), 32'd0);
        start();
        check("chk_clr_err", 32'(load_error), 32'd0);
        send(8'd1);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        send(8'h04);
        check("chk_ok_err", 32'(load_error), 32'd0);
        check("chk_ok_rstn", 32'(cpu_resetn), 32'd1);
        check_mem("chk_mem");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_store.md
INSTRUCTION_STORE -- requirements
Module: instruction_store

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit instruction words (fixed 256 here; address width 8).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  turbo/step strobe from clock divider, forwarded to CPU only in RUN.
REQ-005 SHALL have port load_start  input  1  one-cycle pulse beginning a program load.
REQ-006 SHALL have port load_byte  input  8  program byte stream data.
REQ-007 SHALL have port load_valid  input  1  load_byte valid; byte accepted when load_valid && load_ready at clock edge.
REQ-008 SHALL have port load_ready  output  1  block can accept a byte.
REQ-009 SHALL have port instruction_pointer  input  8  fetch address from CPU.
REQ-010 SHALL have port instruction  output  32  word at instruction_pointer, combinational read.
REQ-011 SHALL have port cpu_enable  output  1  gated enable to CPU.
REQ-012 SHALL have port cpu_resetn  output  1  active-low reset to CPU, holds CPU (pointer = 0) while not running.
REQ-013 SHALL have port load_busy  output  1  load in progress.
REQ-014 SHALL have port load_error  output  1  last load failed (sticky until next load_start or reset).

Function
REQ-015 SHALL implement states IDLE, LEN, DATA, CHK, RUN; state register resets to IDLE.
REQ-016 IDLE: load_start -> LEN; otherwise stay; instruction memory retains contents.
REQ-017 LEN: first accepted byte is word count N; 0 means 256; store count, clear write address to 0, byte index to 0 -> DATA.
REQ-018 DATA: bytes assembled big-endian (byte 0 -> bits 31:24 ... byte 3 -> bits 7:0); word written to memory[write address] on acceptance of byte 3, same edge; address +1, word counter +1.
REQ-019 After word N written: -> CHK if checksum compiled in, else -> RUN next cycle.
REQ-020 Words at addresses >= N SHALL keep their previous contents.
REQ-021 load_ready SHALL be 1 exactly in LEN, DATA, CHK; load_busy likewise.
REQ-022 Bytes with load_valid high in IDLE or RUN SHALL be ignored.
REQ-023 cpu_enable = enable && (state == RUN); cpu_resetn = resetn && (state == RUN).
REQ-024 load_start in any state (including mid-load, RUN) SHALL restart at LEN next edge, clear load_error, discard partial word; cpu_enable/cpu_resetn low from next cycle.
REQ-025 load_start and an accepted byte on the same edge: load_start wins, byte discarded.
REQ-026 Write address SHALL wrap 255 -> 0 only as termination when N = 256 (no overwrite of word 0).
REQ-027 instruction SHALL reflect a word written at edge k from edge k onward (write-then-read, no extra latency).

Reset
REQ-028 resetn low SHALL asynchronously force: state IDLE, load_ready 0, load_busy 0, load_error 0, cpu_enable 0, cpu_resetn 0, byte index 0, write address 0, word counter 0.
REQ-029 Memory contents SHALL NOT be cleared by reset; program survives reset, reload required only after power-up.
REQ-030 After reset, block SHALL remain in IDLE (CPU held) until a load completes.

Configuration
REQ-031 Macro INSTR_STORE_CHECKSUM_EN defined: running XOR of all data bytes (not count byte); CHK accepts one byte; equal -> RUN; unequal -> IDLE with load_error 1.
REQ-032 Macro undefined: no CHK state, no checksum logic, load_error tied 0, DATA -> RUN directly.

Verification
REQ-033 Load N=1, bytes 12 34 56 78 (+chk 08 if enabled) -> memory[0]=32'h12345678, instruction=32'h12345678 at pointer 0, cpu_resetn rises, cpu_enable follows enable.
REQ-034 Load N=0 with 1024 bytes, byte value = address[7:0] pattern -> all 256 words written, memory[0] not overwritten, RUN reached.
REQ-035 load_start after 6 data bytes of N=2 load -> partial word discarded, LEN re-entered, cpu held, new load of N=1 completes correctly, memory[1] unchanged.
REQ-036 Checksum enabled, N=1, bytes 01 02 03 04, chk 05 -> load_error 1, IDLE, cpu_resetn 0; chk 04 -> RUN.
REQ-037 Assert resetn low mid-DATA -> outputs at reset values immediately, previously completed words retained in memory.
REQ-038 load_valid pulses in RUN with random data -> memory and state unchanged, load_ready 0.
